// File: rtl/alarm_clock_core.sv
// -----------------------------------------------------------------------------
// alarm_clock_core
//   Timekeeping core with a built-in one-second tick divider, 12/24 h display
//   hours, NUM_ALARMS programmable alarm channels and an hourly chime, all of
//   which drive a single beep state machine.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-high reset
//   set_mod        level; while high the time loads from set_* every cycle
//   set_hours/minutes/seconds   time to load (clamped to 23/59/59)
//   mode_12h       1 = 12 h display hours, 0 = 24 h
//   chime_en       enable the hourly chime
//   alarm_wr       one-cycle strobe writing channel alarm_sel
//   alarm_sel      channel index; indices >= NUM_ALARMS are ignored
//   alarm_hours/alarm_minutes   alarm time to store (clamped)
//   alarm_en       per-channel enable mask
//   ack            silence the beep and clear alarm_hit
//   hours/minutes/seconds       binary 24 h time
//   disp_hours     display hours (12 h or 24 h mapping)
//   pm             1 when hours >= 12
//   tick           one-cycle pulse per second
//   beep           buzzer drive (registered)
//   alarm_hit      sticky per-channel hit flags
// -----------------------------------------------------------------------------
module alarm_clock_core #(
  parameter int TICK_DIV   = 50,
  parameter int NUM_ALARMS = 4,
  parameter int ALARM_SECS = 10,
  parameter int CHIME_SECS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_mod,
  input  logic [5:0]            set_hours,
  input  logic [5:0]            set_minutes,
  input  logic [5:0]            set_seconds,
  input  logic                  mode_12h,
  input  logic                  chime_en,
  input  logic                  alarm_wr,
  input  logic [2:0]            alarm_sel,
  input  logic [5:0]            alarm_hours,
  input  logic [5:0]            alarm_minutes,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  ack,
  output logic [5:0]            hours,
  output logic [5:0]            minutes,
  output logic [5:0]            seconds,
  output logic [5:0]            disp_hours,
  output logic                  pm,
  output logic                  tick,
  output logic                  beep,
  output logic [NUM_ALARMS-1:0] alarm_hit
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int CNT_MAX = (ALARM_SECS > CHIME_SECS) ? ALARM_SECS : CHIME_SECS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_CHIME = 2'd2
  } state_t;

  // Saturate a 6-bit time field to its legal maximum.
  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] max_v);
    clamp6 = (v > max_v) ? max_v : v;
  endfunction

  logic [DIV_W-1:0]      r_div;
  logic                  r_tick;
  logic [5:0]            r_hours, r_minutes, r_seconds;
  logic [5:0]            r_al_h [NUM_ALARMS];
  logic [5:0]            r_al_m [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_hit;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_beep;

  logic                  w_tick_now;
  logic [5:0]            w_hr_nx, w_min_nx, w_sec_nx;
  logic                  w_roll;
  logic [NUM_ALARMS-1:0] w_match;
  logic                  w_any_match;
  logic                  w_chime_ev;
  state_t                w_state_nx;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic [5:0]            w_disp;

  // The second boundary is the divider's last count; set_mod suppresses it.
  assign w_tick_now = !set_mod && (r_div == DIV_W'(TICK_DIV - 1));

  // Tick divider; tick is registered on the same edge the time advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (set_mod) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (w_tick_now) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  // Next time value: load (clamped), full carry chain on tick, or hold.
  always_comb begin
    w_hr_nx  = r_hours;
    w_min_nx = r_minutes;
    w_sec_nx = r_seconds;
    if (set_mod) begin
      w_hr_nx  = clamp6(set_hours, 6'd23);
      w_min_nx = clamp6(set_minutes, 6'd59);
      w_sec_nx = clamp6(set_seconds, 6'd59);
    end else if (w_tick_now) begin
      if (r_seconds >= 6'd59) begin
        w_sec_nx = 6'd0;
        if (r_minutes >= 6'd59) begin
          w_min_nx = 6'd0;
          if (r_hours >= 6'd23) begin
            w_hr_nx = 6'd0;
          end else begin
            w_hr_nx = r_hours + 6'd1;
          end
        end else begin
          w_min_nx = r_minutes + 6'd1;
        end
      end else begin
        w_sec_nx = r_seconds + 6'd1;
      end
    end else begin
      w_hr_nx  = r_hours;
      w_min_nx = r_minutes;
      w_sec_nx = r_seconds;
    end
  end

  // Time registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hours   <= 6'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
    end else begin
      r_hours   <= w_hr_nx;
      r_minutes <= w_min_nx;
      r_seconds <= w_sec_nx;
    end
  end

  // Alarm channel storage; indices beyond the channel count match no entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_h[i] <= 6'd0;
        r_al_m[i] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_wr && (alarm_sel == 3'(i))) begin
          r_al_h[i] <= clamp6(alarm_hours, 6'd23);
          r_al_m[i] <= clamp6(alarm_minutes, 6'd59);
        end
      end
    end
  end

  // A roll-over to ss = 00 by tick is the only moment alarms are compared;
  // tick is already masked by set_mod, so loading time never matches.
  assign w_roll = w_tick_now && (w_sec_nx == 6'd0);

  // Per-channel match against the time being entered.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (w_roll && alarm_en[i] && (r_al_h[i] == w_hr_nx) && (r_al_m[i] == w_min_nx)) begin
        w_match[i] = 1'b1;
      end else begin
        w_match[i] = 1'b0;
      end
    end
  end

  assign w_any_match = |w_match;
  assign w_chime_ev  = w_roll && chime_en && (w_min_nx == 6'd0);

  // Sticky hit flags; ack beats a coincident match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit <= '0;
    end else if (ack) begin
      r_hit <= '0;
    end else begin
      r_hit <= r_hit | w_match;
    end
  end

  // Beep FSM next state; alarms outrank chimes, ack outranks everything.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (ack) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_match) begin
            w_state_nx = ST_ALARM;
            w_cnt_nx   = CNT_W'(ALARM_SECS);
          end else if (w_chime_ev) begin
            w_state_nx = ST_CHIME;
            w_cnt_nx   = CNT_W'(CHIME_SECS);
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_ALARM, ST_CHIME: begin
          if (w_any_match) begin
            w_state_nx = ST_ALARM;
            w_cnt_nx   = CNT_W'(ALARM_SECS);
          end else if (w_tick_now) begin
            // The last remaining second expires on this tick.
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nx = ST_IDLE;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx   = r_cnt - CNT_W'(1);
            end
          end else begin
            w_state_nx = r_state;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Beep FSM state, counter and registered buzzer drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beep  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_beep  <= (w_state_nx != ST_IDLE);
    end
  end

  // 12 h display mapping: 0 -> 12, 13..23 -> minus 12.
  always_comb begin
    w_disp = r_hours;
    if (mode_12h) begin
      if (r_hours == 6'd0) begin
        w_disp = 6'd12;
      end else if (r_hours > 6'd12) begin
        w_disp = r_hours - 6'd12;
      end else begin
        w_disp = r_hours;
      end
    end else begin
      w_disp = r_hours;
    end
  end

  assign hours      = r_hours;
  assign minutes    = r_minutes;
  assign seconds    = r_seconds;
  assign disp_hours = w_disp;
  assign pm         = (r_hours >= 6'd12);
  assign tick       = r_tick;
  assign beep       = r_beep;
  assign alarm_hit  = r_hit;

endmodule

// File: tb/tb_alarm_clock_core.sv
// -----------------------------------------------------------------------------
// tb_alarm_clock_core
//   Self-checking bench for alarm_clock_core with TICK_DIV = 4, NUM_ALARMS = 4,
//   ALARM_SECS = 3, CHIME_SECS = 1. A vector table covers time loading,
//   clamping and the 12 h mapping; hand-written sequences cover ticking,
//   carries, alarms, chime, ack and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_alarm_clock_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_mod;
  logic [5:0] set_hours, set_minutes, set_seconds;
  logic       mode_12h;
  logic       chime_en;
  logic       alarm_wr;
  logic [2:0] alarm_sel;
  logic [5:0] alarm_hours, alarm_minutes;
  logic [3:0] alarm_en;
  logic       ack;
  logic [5:0] hours, minutes, seconds, disp_hours;
  logic       pm, tick, beep;
  logic [3:0] alarm_hit;

  int n_checks = 0;
  int n_errors = 0;

  alarm_clock_core #(
    .TICK_DIV  (4),
    .NUM_ALARMS(4),
    .ALARM_SECS(3),
    .CHIME_SECS(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .set_mod      (set_mod),
    .set_hours    (set_hours),
    .set_minutes  (set_minutes),
    .set_seconds  (set_seconds),
    .mode_12h     (mode_12h),
    .chime_en     (chime_en),
    .alarm_wr     (alarm_wr),
    .alarm_sel    (alarm_sel),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .alarm_en     (alarm_en),
    .ack          (ack),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .disp_hours   (disp_hours),
    .pm           (pm),
    .tick         (tick),
    .beep         (beep),
    .alarm_hit    (alarm_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sh, sm, ss;
    logic       m12;
    logic [5:0] eh, em, es, ed;
    logic       epm;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    check({name, ".hours"}, 32'(hours), 32'(h));
    check({name, ".minutes"}, 32'(minutes), 32'(m));
    check({name, ".seconds"}, 32'(seconds), 32'(s));
  endtask

  // Load a time with a one-cycle set_mod pulse; divider restarts from 0.
  task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    set_mod = 1'b1; set_hours = h; set_minutes = m; set_seconds = s;
    @(posedge clk);
    @(negedge clk);
    set_mod = 1'b0;
  endtask

  task automatic write_alarm(input logic [2:0] sel, input logic [5:0] h, input logic [5:0] m);
    @(negedge clk);
    alarm_wr = 1'b1; alarm_sel = sel; alarm_hours = h; alarm_minutes = m;
    @(negedge clk);
    alarm_wr = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack.beep", 32'(beep), 32'd0);
    check("ack.alarm_hit", 32'(alarm_hit), 32'd0);
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Wait for the next tick pulse, bounded; returns 1 ns after that edge.
  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: tick not seen within 20 cycles, expected a tick", name);
    end
  endtask

  initial begin
    // Loading, clamping and 12 h mapping vectors.
    vecs[0] = '{6'd0,  6'd0,  6'd0,  1'b1, 6'd0,  6'd0,  6'd0,  6'd12, 1'b0};
    vecs[1] = '{6'd0,  6'd0,  6'd0,  1'b0, 6'd0,  6'd0,  6'd0,  6'd0,  1'b0};
    vecs[2] = '{6'd1,  6'd5,  6'd7,  1'b1, 6'd1,  6'd5,  6'd7,  6'd1,  1'b0};
    vecs[3] = '{6'd11, 6'd59, 6'd59, 1'b1, 6'd11, 6'd59, 6'd59, 6'd11, 1'b0};
    vecs[4] = '{6'd12, 6'd0,  6'd0,  1'b1, 6'd12, 6'd0,  6'd0,  6'd12, 1'b1};
    vecs[5] = '{6'd12, 6'd30, 6'd0,  1'b0, 6'd12, 6'd30, 6'd0,  6'd12, 1'b1};
    vecs[6] = '{6'd13, 6'd0,  6'd0,  1'b1, 6'd13, 6'd0,  6'd0,  6'd1,  1'b1};
    vecs[7] = '{6'd23, 6'd59, 6'd59, 1'b1, 6'd23, 6'd59, 6'd59, 6'd11, 1'b1};
    vecs[8] = '{6'd40, 6'd63, 6'd63, 1'b0, 6'd23, 6'd59, 6'd59, 6'd23, 1'b1};
    vecs[9] = '{6'd24, 6'd60, 6'd60, 1'b1, 6'd23, 6'd59, 6'd59, 6'd11, 1'b1};

    reset = 1'b1; set_mod = 1'b0; set_hours = 6'd0; set_minutes = 6'd0; set_seconds = 6'd0;
    mode_12h = 1'b1; chime_en = 1'b0; alarm_wr = 1'b0; alarm_sel = 3'd0;
    alarm_hours = 6'd0; alarm_minutes = 6'd0; alarm_en = 4'b0000; ack = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_time("reset", 6'd0, 6'd0, 6'd0);
    check("reset.disp_hours", 32'(disp_hours), 32'd12);
    check("reset.pm", 32'(pm), 32'd0);
    check("reset.tick", 32'(tick), 32'd0);
    check("reset.beep", 32'(beep), 32'd0);
    check("reset.alarm_hit", 32'(alarm_hit), 32'd0);

    // Free run: ticks on cycles 4, 8, 12.
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("run.tick.c%0d", c), 32'(tick), ((c % 4) == 0) ? 32'd1 : 32'd0);
    end
    check("run.seconds", 32'(seconds), 32'd3);
    check("run.beep", 32'(beep), 32'd0);

    // Table: held set_mod loads every cycle and suppresses tick.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      set_mod = 1'b1; set_hours = vecs[v].sh; set_minutes = vecs[v].sm;
      set_seconds = vecs[v].ss; mode_12h = vecs[v].m12;
      @(posedge clk);
      #1;
      check_time($sformatf("vec%0d", v), vecs[v].eh, vecs[v].em, vecs[v].es);
      check($sformatf("vec%0d.disp_hours", v), 32'(disp_hours), 32'(vecs[v].ed));
      check($sformatf("vec%0d.pm", v), 32'(pm), 32'(vecs[v].epm));
      check($sformatf("vec%0d.tick", v), 32'(tick), 32'd0);
    end
    repeat (6) @(posedge clk);
    #1;
    check_time("setheld", 6'd23, 6'd59, 6'd59);
    check("setheld.tick", 32'(tick), 32'd0);
    @(negedge clk);
    set_mod = 1'b0;
    mode_12h = 1'b1;

    // Full carry chain across midnight.
    set_time(6'd23, 6'd59, 6'd58);
    wait_tick("mid1");
    check_time("mid1", 6'd23, 6'd59, 6'd59);
    check("mid1.disp_hours", 32'(disp_hours), 32'd11);
    check("mid1.pm", 32'(pm), 32'd1);
    wait_tick("mid2");
    check_time("mid2", 6'd0, 6'd0, 6'd0);
    check("mid2.disp_hours", 32'(disp_hours), 32'd12);
    check("mid2.pm", 32'(pm), 32'd0);
    check("mid2.beep", 32'(beep), 32'd0);

    // Alarm on channel 2 beeps for three ticks, hit stays sticky.
    write_alarm(3'd2, 6'd7, 6'd30);
    alarm_en = 4'b0100;
    set_time(6'd7, 6'd29, 6'd59);
    wait_tick("al.t0");
    check_time("al.t0", 6'd7, 6'd30, 6'd0);
    check("al.t0.alarm_hit", 32'(alarm_hit), 32'b0100);
    check("al.t0.beep", 32'(beep), 32'd1);
    wait_tick("al.t1");
    check("al.t1.beep", 32'(beep), 32'd1);
    wait_tick("al.t2");
    check("al.t2.beep", 32'(beep), 32'd1);
    @(posedge clk);
    #1;
    check("al.t2b.beep", 32'(beep), 32'd1);
    wait_tick("al.t3");
    check("al.t3.beep", 32'(beep), 32'd0);
    check("al.t3.alarm_hit", 32'(alarm_hit), 32'b0100);
    pulse_ack();

    // Ack during the beep silences it on the next cycle.
    set_time(6'd7, 6'd29, 6'd59);
    wait_tick("ak.t0");
    check("ak.t0.beep", 32'(beep), 32'd1);
    wait_tick("ak.t1");
    check("ak.t1.beep", 32'(beep), 32'd1);
    pulse_ack();
    wait_tick("ak.t2");
    check("ak.t2.beep", 32'(beep), 32'd0);

    // Ack coinciding with the matching tick wins.
    set_time(6'd7, 6'd29, 6'd59);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("akm.tick", 32'(tick), 32'd1);
    check_time("akm", 6'd7, 6'd30, 6'd0);
    check("akm.beep", 32'(beep), 32'd0);
    check("akm.alarm_hit", 32'(alarm_hit), 32'd0);
    @(negedge clk);
    ack = 1'b0;

    // Hour boundary with an enabled alarm: alarm wins, three-tick beep.
    chime_en = 1'b1;
    write_alarm(3'd0, 6'd10, 6'd0);
    alarm_en = 4'b0001;
    set_time(6'd9, 6'd59, 6'd59);
    wait_tick("ca.t0");
    check_time("ca.t0", 6'd10, 6'd0, 6'd0);
    check("ca.t0.beep", 32'(beep), 32'd1);
    check("ca.t0.alarm_hit", 32'(alarm_hit), 32'b0001);
    wait_tick("ca.t1");
    check("ca.t1.beep", 32'(beep), 32'd1);
    wait_tick("ca.t2");
    check("ca.t2.beep", 32'(beep), 32'd1);
    wait_tick("ca.t3");
    check("ca.t3.beep", 32'(beep), 32'd0);
    pulse_ack();

    // Chime alone: one-tick beep, no hit.
    alarm_en = 4'b0000;
    set_time(6'd9, 6'd59, 6'd59);
    wait_tick("ch.t0");
    check("ch.t0.beep", 32'(beep), 32'd1);
    check("ch.t0.alarm_hit", 32'(alarm_hit), 32'd0);
    wait_tick("ch.t1");
    check("ch.t1.beep", 32'(beep), 32'd0);
    chime_en = 1'b0;

    // Out-of-range channel index writes nothing.
    write_alarm(3'd5, 6'd8, 6'd0);
    alarm_en = 4'b1111;
    set_time(6'd7, 6'd59, 6'd59);
    wait_tick("sel5");
    check_time("sel5", 6'd8, 6'd0, 6'd0);
    check("sel5.alarm_hit", 32'(alarm_hit), 32'd0);
    check("sel5.beep", 32'(beep), 32'd0);
    // Channels 1 and 3 still hold their reset value 00:00.
    set_time(6'd23, 6'd59, 6'd59);
    wait_tick("zero");
    check("zero.alarm_hit", 32'(alarm_hit), 32'b1010);
    check("zero.beep", 32'(beep), 32'd1);
    pulse_ack();

    // Alarm write is clamped to 23:59.
    write_alarm(3'd3, 6'd30, 6'd63);
    alarm_en = 4'b1000;
    set_time(6'd23, 6'd58, 6'd59);
    wait_tick("clamp");
    check("clamp.alarm_hit", 32'(alarm_hit), 32'b1000);
    check("clamp.beep", 32'(beep), 32'd1);
    wait_tick("clamp.t1");
    check("clamp.t1.beep", 32'(beep), 32'd1);

    // Asynchronous reset mid-alarm, sampled before any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_time("arst", 6'd0, 6'd0, 6'd0);
    check("arst.beep", 32'(beep), 32'd0);
    check("arst.tick", 32'(tick), 32'd0);
    check("arst.alarm_hit", 32'(alarm_hit), 32'd0);
    check("arst.disp_hours", 32'(disp_hours), 32'd12);
    check("arst.pm", 32'(pm), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
